// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pkg
// Shared types and constants for the LC-3 style SRAM access controller.
//   mem_state_t    : controller state encoding
//   IO_ADDR        : word address that maps to the switch/hex I/O port
//   mem_strobes_t  : bundle of active-low SRAM strobes plus bus drive enable
//   decode_strobes : combinational strobe decode from state and direction
// ---------------------------------------------------------------------------
package lc3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        DONE
    } mem_state_t;

    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    typedef struct packed {
        logic ce;
        logic ub;
        logic lb;
        logic oe;
        logic we;
        logic drive_en;
    } mem_strobes_t;

    // rw: 1 = write, 0 = read. io_sel masks every SRAM strobe so the I/O
    // port transfer never touches the memory chip.
    function automatic mem_strobes_t decode_strobes(input mem_state_t st,
                                                    input logic       rw,
                                                    input logic       io_sel);
        mem_strobes_t s;
        s = '{ce: 1'b1, ub: 1'b1, lb: 1'b1, oe: 1'b1, we: 1'b1, drive_en: 1'b0};
        unique case (st)
            SETUP: begin
                s.ce       = 1'b0;
                s.ub       = 1'b0;
                s.lb       = 1'b0;
                s.oe       = rw;
                s.drive_en = rw;
            end
            ACCESS: begin
                s.ce       = 1'b0;
                s.ub       = 1'b0;
                s.lb       = 1'b0;
                s.oe       = rw;
                s.we       = ~rw;
                s.drive_en = rw;
            end
            HOLD: begin
                // Only writes reach HOLD; gating with rw keeps the bus
                // undriven for reads even if the state were ever corrupted.
                s.ce       = 1'b0;
                s.ub       = 1'b0;
                s.lb       = 1'b0;
                s.drive_en = rw;
            end
            default: ;
        endcase
        if (io_sel) begin
            s.ce = 1'b1;
            s.ub = 1'b1;
            s.lb = 1'b1;
            s.oe = 1'b1;
            s.we = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Sequences one CPU word transfer to an asynchronous SRAM:
// IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> (HOLD, writes only) -> DONE.
//
// Ports
//   Clk, Reset (async, active-low)
//   Req, R_W, Addr, Wr_Data     : CPU request, sampled only in IDLE
//   Rd_Data, Ready, Busy        : read result, completion pulse, busy flag
//   SRAM_ADDR, Mem_CE/UB/LB/OE/WE : SRAM address and active-low strobes
//   Data_Out, Data_In, Drive_En : external tristate bus buffer
//   Switches, Hex_Data          : only when MEM_IO_MAP_EN is defined
//
// Build option: define MEM_IO_MAP_EN to map Addr 16'hFFFF onto the
// Switches input (reads) and the Hex_Data register (writes).
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import lc3_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        R_W,
    input  logic [15:0] Addr,
    input  logic [15:0] Wr_Data,
    output logic [15:0] Rd_Data,
    output logic        Ready,
    output logic        Busy,
    output logic [19:0] SRAM_ADDR,
    output logic        Mem_CE,
    output logic        Mem_UB,
    output logic        Mem_LB,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [15:0] Data_Out,
    input  logic [15:0] Data_In,
    output logic        Drive_En
`ifdef MEM_IO_MAP_EN
    ,
    input  logic [15:0] Switches,
    output logic [15:0] Hex_Data
`endif
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    mem_state_t   state_q;
    logic [15:0]  addr_q;
    logic [15:0]  wdata_q;
    logic         rw_q;
    logic [3:0]   cnt_q;
    logic [15:0]  rd_data_q;
    logic         ready_q;
    logic         busy_q;
    logic         io_sel;
    logic [15:0]  rd_src;
    mem_strobes_t strb;

`ifdef MEM_IO_MAP_EN
    logic [15:0] hex_q;

    assign io_sel = (addr_q == IO_ADDR);
    assign rd_src = io_sel ? Switches : Data_In;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hex_q <= 16'h0000;
        end else if (state_q == HOLD && io_sel) begin
            hex_q <= wdata_q;
        end
    end

    assign Hex_Data = hex_q;
`else
    assign io_sel = 1'b0;
    assign rd_src = Data_In;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            rw_q      <= 1'b0;
            cnt_q     <= 4'd0;
            rd_data_q <= 16'h0000;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (Req) begin
                        addr_q  <= Addr;
                        wdata_q <= Wr_Data;
                        rw_q    <= R_W;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    cnt_q <= cnt_q - 4'd1;
                    // cnt_q == 1 marks the final ACCESS cycle.
                    if (cnt_q == 4'd1) begin
                        if (rw_q) begin
                            state_q <= HOLD;
                        end else begin
                            rd_data_q <= rd_src;
                            ready_q   <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                HOLD: begin
                    ready_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign strb = decode_strobes(state_q, rw_q, io_sel);

    assign Mem_CE    = strb.ce;
    assign Mem_UB    = strb.ub;
    assign Mem_LB    = strb.lb;
    assign Mem_OE    = strb.oe;
    assign Mem_WE    = strb.we;
    assign Drive_En  = strb.drive_en;
    assign SRAM_ADDR = {4'h0, addr_q};
    assign Data_Out  = wdata_q;
    assign Rd_Data   = rd_data_q;
    assign Ready     = ready_q;
    assign Busy      = busy_q;

endmodule
